// File: rtl/fifo_stream_out_if.sv
// Bus bundle between fifo_stream_out and its neighbours.
// FX2LP slave-FIFO signals, plus the byte stream handed to the downstream consumer.
// Modport master is the fifo_stream_out side. Modport slave is the FX2LP/consumer side.
//   flaga, fdata          : EP2 empty flag (active low) and data bus from FX2LP
//   faddr, sloe, slrd,    : FIFO select, output enable, read strobe, write strobe,
//   slwr, pkt_end           packet end towards FX2LP
//   out_data/valid/ready  : valid-ready byte stream towards the consumer
interface fifo_stream_out_if;
  logic       flaga;
  logic [7:0] fdata;
  logic [1:0] faddr;
  logic       sloe;
  logic       slrd;
  logic       slwr;
  logic       pkt_end;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  flaga, fdata, out_ready,
    output faddr, sloe, slrd, slwr, pkt_end, out_data, out_valid
  );

  modport slave (
    output flaga, fdata, out_ready,
    input  faddr, sloe, slrd, slwr, pkt_end, out_data, out_valid
  );
endinterface

// File: rtl/fifo_stream_out.sv
// Reads EP2 of an FX2LP slave FIFO and buffers the bytes into a valid-ready stream.
// Latency: a byte is on out_data one cycle after the edge that pushes it; slrd goes low 2 cycles after IDLE sees data.
// Backpressure: reading pauses once the buffer holds PAUSE_LEVEL bytes, and resumes when the consumer drains it below that level.
// Ports: clk/rst (sync, active high), bus (fifo_stream_out_if.master), clk_o (= clk),
//        level (buffer occupancy), rx_count (push counter, only with FIFO_STREAM_OUT_BYTE_COUNT_EN).
// Optional feature macro: FIFO_STREAM_OUT_BYTE_COUNT_EN adds the 16-bit wrapping rx_count output.
module fifo_stream_out #(
  parameter int DEPTH       = 8,
  parameter int PAUSE_LEVEL = DEPTH - 3
) (
  input  logic                     clk,
  input  logic                     rst,
  fifo_stream_out_if.master        bus,
  output logic                     clk_o,
  output logic [$clog2(DEPTH):0]   level
`ifdef FIFO_STREAM_OUT_BYTE_COUNT_EN
  ,
  output logic [15:0]              rx_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_READ   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sloe_q, slrd_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            can_read;
  logic            push, pop;

  // Constant FX2LP controls: always EP2, never writing, never ending packets.
  assign bus.faddr   = 2'b00;
  assign bus.slwr    = 1'b1;
  assign bus.pkt_end = 1'b1;
  assign clk_o       = clk;

  assign bus.sloe      = sloe_q;
  assign bus.slrd      = slrd_q;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = (level_q != '0);
  assign level         = level_q;

  // EP2 has data and there is room beyond the two bytes that may still
  // land while the registered strobe catches up with a pause decision.
  assign can_read = bus.flaga && (level_q < LW'(PAUSE_LEVEL));

  // A byte is taken on every edge where the registered strobe is low and
  // EP2 is not empty. The full test is a backstop for unusual PAUSE_LEVEL values.
  assign push = !slrd_q && bus.flaga && (level_q != LW'(DEPTH));
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = can_read ? S_SELECT : S_IDLE;
      S_SELECT: state_d = S_READ;   // one cycle of bus turnaround after sloe falls
      S_READ:   state_d = can_read ? S_READ : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Strobes are registered from the next state so that slrd is low exactly
  // while the FSM sits in READ and sloe is low in SELECT and READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sloe_q   <= 1'b1;
      slrd_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      sloe_q   <= (state_d == S_IDLE);
      slrd_q   <= (state_d != S_READ);
      level_q  <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset; the in-flight byte on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.fdata;
  end

`ifdef FIFO_STREAM_OUT_BYTE_COUNT_EN
  logic [15:0] rx_count_q;

  always_ff @(posedge clk) begin
    if (rst)       rx_count_q <= '0;
    else if (push) rx_count_q <= rx_count_q + 16'd1;
  end

  assign rx_count = rx_count_q;
`endif

endmodule
